// File: rtl/chan_mux_pkg.sv
// Shared definitions for the chan_mux_seq channel selector: mode encoding,
// default dwell length and a portable ceil-log2 helper.
package chan_mux_pkg;

  localparam int DWELL_DEFAULT = 1024;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  function automatic int clog2_f(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/chan_mux_seq_if.sv
// Channel selector bus: control, packed channel inputs and registered outputs.
// Carries dout_par when CHMUX_PARITY_EN is defined.
interface chan_mux_seq_if
  import chan_mux_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CH    = 8
);

  localparam int SEL_W = clog2_f(CH);

  logic                  auto_en;
  logic                  hold;
  logic [SEL_W-1:0]      sel;
  logic [CH*WIDTH-1:0]   din;
  logic [WIDTH-1:0]      dout;
  logic [SEL_W-1:0]      cur_ch;
  logic                  ch_chg;
`ifdef CHMUX_PARITY_EN
  logic                  dout_par;

  modport master (output auto_en, hold, sel, din,
                  input  dout, cur_ch, ch_chg, dout_par);
  modport slave  (input  auto_en, hold, sel, din,
                  output dout, cur_ch, ch_chg, dout_par);
`else
  modport master (output auto_en, hold, sel, din,
                  input  dout, cur_ch, ch_chg);
  modport slave  (input  auto_en, hold, sel, din,
                  output dout, cur_ch, ch_chg);
`endif

endinterface

// File: rtl/chan_mux_seq_scan_timer.sv
// Dwell counter for auto-scan: counts 0..DWELL-1 while run is high and
// raises tick combinationally on the last count so the wrap lands on that edge.
module scan_timer
  import chan_mux_pkg::*;
#(
  parameter int DWELL = DWELL_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = clog2_f(DWELL + 1);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;

  assign tick = run && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/chan_mux_seq.sv
// Registered CH-way, WIDTH-bit channel selector with manual and auto-scan modes,
// hold and a channel-change strobe. Optional dout_par via CHMUX_PARITY_EN.
module chan_mux_seq
  import chan_mux_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CH    = 8,
  parameter int DWELL = DWELL_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  chan_mux_seq_if.slave bus
);

  localparam int               SEL_W   = clog2_f(CH);
  localparam logic [SEL_W:0]   CH_LIM  = (SEL_W + 1)'(CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CH - 1);

  mode_e            mode;
  logic             run;
  logic             clr;
  logic             tick;
  logic [WIDTH-1:0] lane [CH];
  logic [SEL_W-1:0] cur_ch_next;
  logic [WIDTH-1:0] dout_next;
  logic [SEL_W-1:0] cur_ch_q;
  logic [WIDTH-1:0] dout_q;
  logic             ch_chg_q;

  for (genvar k = 0; k < CH; k++) begin : g_lane
    assign lane[k] = bus.din[k*WIDTH +: WIDTH];
  end

  assign mode = bus.auto_en ? MODE_AUTO : MODE_MANUAL;
  assign run  = (mode == MODE_AUTO)   && !bus.hold;
  assign clr  = (mode == MODE_MANUAL) && !bus.hold;

  scan_timer #(.DWELL(DWELL)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .clr  (clr),
    .tick (tick)
  );

  // An out-of-range manual select keeps the previous channel.
  always_comb begin
    // NOTE: default first so every path assigns cur_ch_next and no latch is inferred.
    cur_ch_next = cur_ch_q;
    if (!bus.hold) begin
      if (mode == MODE_AUTO) begin
        if (tick) begin
          cur_ch_next = (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + SEL_W'(1);
        end
      end else if ({1'b0, bus.sel} < CH_LIM) begin
        cur_ch_next = bus.sel;
      end
    end
  end

  assign dout_next = lane[cur_ch_next];

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values of the others.
    if (rst) begin
      cur_ch_q <= '0;
      dout_q   <= '0;
      ch_chg_q <= 1'b0;
    end else if (!bus.hold) begin
      cur_ch_q <= cur_ch_next;
      dout_q   <= dout_next;
      ch_chg_q <= (cur_ch_next != cur_ch_q);
    end else begin
      ch_chg_q <= 1'b0;
    end
  end

  assign bus.dout   = dout_q;
  assign bus.cur_ch = cur_ch_q;
  assign bus.ch_chg = ch_chg_q;

`ifdef CHMUX_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (!bus.hold) begin
      par_q <= ^dout_next;
    end
  end

  assign bus.dout_par = par_q;
`endif

endmodule

// File: doc/chan_mux_seq.md
Name: chan_mux_seq

Overview:
- Registered N-channel, parametrised-width data selector for the IO subsystem. Generalises the 2:1 64-bit combinational selector.
- Feeds the display/IO output path from CH source buses.
- Manual mode: channel comes from `sel`.
- Auto-scan mode: an internal dwell counter rotates through the channels.
- A hold input freezes the output, and a change-strobe output flags every channel switch.

Parameters:
- WIDTH, 64, bits per channel.
- CH, 8, number of input channels (2..16).
- DWELL, 1024, auto-scan cycles spent on each channel (>=1).
- SEL_W, $clog2(CH), derived; not to be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- auto_en  in  1  1 = auto-scan mode, 0 = manual mode.
- hold  in  1  1 = freeze dout, cur_ch and the dwell counter.
- sel  in  SEL_W  manual channel select.
- din  in  CH*WIDTH  packed inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- dout  out  WIDTH  registered selected data.
- cur_ch  out  SEL_W  channel currently driving dout.
- ch_chg  out  1  one-cycle pulse when cur_ch changes.

Behaviour:
- Reset (rst=1 at a clk edge):
  - dout=0, cur_ch=0, ch_chg=0, dwell counter=0.
  - Reset dominates hold and auto_en.
- Latency: dout(t+1) = din[cur_ch_next(t)] sampled at edge t, i.e. one register stage. cur_ch and dout update on the same edge.
- hold=1 (not in reset):
  - All registers keep their value; ch_chg=0.
  - Input changes are ignored.
  - On release, operation resumes with the retained counter value.
- Manual mode (auto_en=0, hold=0):
  - If sel<CH: cur_ch_next = sel.
  - If sel>=CH (possible only when CH is not a power of two): cur_ch_next = cur_ch, i.e. hold the previous channel; never select out of range.
  - The dwell counter is held at 0.
- Auto mode (auto_en=1, hold=0):
  - Counter counts 0..DWELL-1.
  - At DWELL-1 the counter wraps to 0 and cur_ch_next = (cur_ch==CH-1) ? 0 : cur_ch+1.
  - Otherwise cur_ch_next = cur_ch.
  - dout still reloads every cycle from din[cur_ch_next], so live data is tracked.
- Mode switch manual->auto: scanning starts from the current cur_ch with the counter at 0. The first advance occurs DWELL cycles after auto_en rises.
- Mode switch auto->manual: the next edge uses sel; the counter clears to 0.
- DWELL=1: the channel advances every cycle.
- ch_chg(t+1) = (cur_ch_next != cur_ch) at edge t.
  - No pulse on reset.
  - No pulse when sel is rewritten with the same value.
- Width rule: dout is exactly WIDTH bits; no sign or extension logic. The counter is $clog2(DWELL+1) bits wide.

Optional Feature:
- Macro CHMUX_PARITY_EN.
- Defined:
  - Adds output port dout_par (1 bit) = even parity (XOR reduction) of the next dout value, registered in the same stage as dout.
  - Reset value 0; frozen by hold.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package chan_mux_pkg:
  - Function clog2_f (for tool portability).
  - Localparam DWELL_DEFAULT=1024.
  - Typedef for mode encoding (MODE_MANUAL=0, MODE_AUTO=1).
- One natural sub-module: scan_timer. It holds the dwell counter and the wrap strobe, with inputs clk, rst, run, clr and output tick.
- The selector and output registers stay in the top module.

Test Plan:
- Reset release: rst=1 for 3 cycles with arbitrary din -> dout=0, cur_ch=0, ch_chg=0 throughout; first edge after release with sel=3, auto_en=0 -> cur_ch=3, dout=din[3], ch_chg=1 for one cycle.
- Manual latency: din[5]=64'hDEADBEEF_01234567, sel=5 from t0 -> dout equals that value exactly at t0+1; change din[5] to 64'h1 at t0+4 -> dout=1 at t0+5.
- Auto scan with DWELL=4, CH=8:
  - auto_en=1 from cur_ch=6 -> cur_ch sequence 6,7,0,1, each held 4 cycles.
  - ch_chg pulses at each transition, including the 7->0 wrap.
- Hold mid-dwell: in auto mode, assert hold at counter=2 for 10 cycles -> dout, cur_ch and the counter are unchanged and ch_chg=0; the advance occurs 2 cycles after hold drops.
- Out-of-range select with CH=6: sel=2 and then sel=7 -> cur_ch stays 2 and ch_chg=0; sel=4 -> cur_ch=4.
- Parity with CHMUX_PARITY_EN defined: din[sel]=64'h7 -> dout_par=1; din[sel]=64'h3 -> dout_par=0; both with one-cycle latency.
